// File: rtl/ex_mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO: fixed-latency multiply, restoring divide
// producing one quotient bit per cycle, plus MTHI/MTLO writes.
module ex_mult_div_unit #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MULT_STAGES = 2
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Start_EX,
   input  logic [2:0]            Op_EX,
   input  logic [DATA_WIDTH-1:0] Operand_A_EX,
   input  logic [DATA_WIDTH-1:0] Operand_B_EX,
   input  logic                  Flush_EX,
   output logic                  Busy_EX,
   output logic                  Done_EX,
   output logic [DATA_WIDTH-1:0] HI_EX,
   output logic [DATA_WIDTH-1:0] LO_EX
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(W);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] MUL_PIPE = 2'd1;
   localparam logic [1:0] DIV_ITER = 2'd2;
   localparam logic [1:0] DIV_FIX  = 2'd3;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     op_a_q, op_a_d;
   logic [W-1:0]     op_b_q, op_b_d;
   logic             mul_signed_q, mul_signed_d;
   logic [W-1:0]     quo_q, quo_d;
   logic [W-1:0]     rem_q, rem_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;

   logic           accept;
   logic           div_signed;
   logic           a_neg, b_neg;
   logic [W-1:0]   a_mag, b_mag;
   logic [2*W-1:0] mul_a_ext, mul_b_ext, mul_prod;
   logic [W:0]     rem_shift;
   logic           rem_ge;
   logic [W-1:0]   rem_diff;

   assign accept     = Start_EX && !busy_q && (state_q == IDLE) && !Flush_EX;
   assign div_signed = (Op_EX == OP_DIV);
   assign a_neg      = div_signed && Operand_A_EX[W-1];
   assign b_neg      = div_signed && Operand_B_EX[W-1];
   assign a_mag      = a_neg ? -Operand_A_EX : Operand_A_EX;
   assign b_mag      = b_neg ? -Operand_B_EX : Operand_B_EX;

   // Low 2W bits of the extended product are exact for both signed and unsigned operands.
   assign mul_a_ext = {{W{mul_signed_q & op_a_q[W-1]}}, op_a_q};
   assign mul_b_ext = {{W{mul_signed_q & op_b_q[W-1]}}, op_b_q};
   assign mul_prod  = mul_a_ext * mul_b_ext;

   assign rem_shift = {rem_q, quo_q[W-1]};
   assign rem_ge    = rem_shift >= {1'b0, op_b_q};
   assign rem_diff  = rem_shift[W-1:0] - op_b_q;

   always_comb begin
      state_d      = state_q;
      done_d       = 1'b0;
      hi_d         = hi_q;
      lo_d         = lo_q;
      cnt_d        = cnt_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      mul_signed_d = mul_signed_q;
      quo_d        = quo_q;
      rem_d        = rem_q;
      q_neg_d      = q_neg_q;
      r_neg_d      = r_neg_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (Op_EX)
                  OP_MULT, OP_MULTU: begin
                     op_a_d       = Operand_A_EX;
                     op_b_d       = Operand_B_EX;
                     mul_signed_d = (Op_EX == OP_MULT);
                     cnt_d        = CNT_W'(MULT_STAGES - 1);
                     state_d      = MUL_PIPE;
                  end
                  OP_DIV, OP_DIVU: begin
                     q_neg_d = 1'b0;
                     r_neg_d = 1'b0;
                     if (Operand_B_EX == '0) begin
                        quo_d   = '1;
                        rem_d   = Operand_A_EX;
                        state_d = DIV_FIX;
                     end else if (div_signed && (Operand_A_EX == MIN_VAL) &&
                                  (Operand_B_EX == '1)) begin
                        quo_d   = MIN_VAL;
                        rem_d   = '0;
                        state_d = DIV_FIX;
                     end else begin
                        quo_d   = a_mag;
                        rem_d   = '0;
                        op_b_d  = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        cnt_d   = CNT_W'(W - 1);
                        state_d = DIV_ITER;
                     end
                  end
                  OP_MTHI: begin
                     hi_d   = Operand_A_EX;
                     done_d = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_d   = Operand_A_EX;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         MUL_PIPE: begin
            if (Flush_EX) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               {hi_d, lo_d} = mul_prod;
               done_d       = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DIV_ITER: begin
            if (Flush_EX) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_ge ? rem_diff : rem_shift[W-1:0];
               quo_d = {quo_q[W-2:0], rem_ge};
               if (cnt_q == '0) begin
                  state_d = DIV_FIX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         DIV_FIX: begin
            if (Flush_EX) begin
               state_d = IDLE;
            end else begin
               lo_d    = q_neg_q ? -quo_q : quo_q;
               hi_d    = r_neg_q ? -rem_q : rem_q;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         cnt_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         mul_signed_q <= 1'b0;
         quo_q        <= '0;
         rem_q        <= '0;
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         cnt_q        <= cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         mul_signed_q <= mul_signed_d;
         quo_q        <= quo_d;
         rem_q        <= rem_d;
         q_neg_q      <= q_neg_d;
         r_neg_q      <= r_neg_d;
      end
   end

   assign Busy_EX = busy_q;
   assign Done_EX = done_q;
   assign HI_EX   = hi_q;
   assign LO_EX   = lo_q;

endmodule
